// File: rtl/stg_if.sv
// rtl/stg_if.sv - instruction-fetch stage: credit-limited fetch issue, response FIFO, decode handoff
module stg_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 24,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_flush,
  input  logic [ADDR_W-1:0] iw_flush_pc,
  input  logic              iw_stall,
  output logic              ow_imem_req,
  output logic [ADDR_W-1:0] ow_imem_addr,
  input  logic              iw_imem_gnt,
  input  logic              iw_imem_rvalid,
  input  logic [DATA_W-1:0] iw_imem_rdata,
  output logic [ADDR_W-1:0] ow_pc,
  output logic [DATA_W-1:0] ow_instr,
  output logic              ow_valid
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     outs_q, outs_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;

  logic [ADDR_W-1:0] pc_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] instr_mem [FIFO_DEPTH];

  logic [CW:0] credit_used;
  logic        grant;
  logic        rsp;
  logic        push;
  logic        pop;

  // Credit covers both in-flight requests and buffered words, so a push can never overflow the FIFO.
  assign credit_used  = {1'b0, outs_q} + {1'b0, cnt_q};
  assign ow_imem_req  = !iw_rst && !iw_flush && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign ow_imem_addr = fetch_pc_q;
  assign grant        = ow_imem_req && iw_imem_gnt;
  assign rsp          = iw_imem_rvalid && (outs_q != '0);
  assign push         = rsp && !iw_flush && (drop_q == '0);
  assign pop          = !iw_flush && !iw_stall && (cnt_q != '0);

  assign ow_pc    = pc_q;
  assign ow_instr = instr_q;
  assign ow_valid = valid_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outs_d     = outs_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;

    if (iw_flush) begin
      // Every request still outstanding after this cycle belongs to the old stream.
      fetch_pc_d = iw_flush_pc;
      resp_pc_d  = iw_flush_pc;
      outs_d     = outs_q - CW'(rsp);
      drop_d     = outs_q - CW'(rsp);
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pc_d       = '0;
      instr_d    = '0;
      valid_d    = 1'b0;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      outs_d = outs_q + CW'(grant) - CW'(rsp);
      if (rsp) begin
        if (drop_q != '0) drop_d = drop_q - CW'(1);
        else              resp_pc_d = resp_pc_q + ADDR_W'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

      if (!iw_stall) begin
        if (cnt_q != '0) begin
          pc_d    = pc_mem[rd_ptr_q];
          instr_d = instr_mem[rd_ptr_q];
          valid_d = 1'b1;
        end else begin
          pc_d    = '0;
          instr_d = '0;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outs_q     <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pc_q       <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outs_q     <= outs_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge iw_clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= resp_pc_q;
      instr_mem[wr_ptr_q] <= iw_imem_rdata;
    end
  end

endmodule

// File: tb/tb_stg_if.sv
// tb/tb_stg_if.sv - randomized self-checking bench for stg_if against an epoch-tagged fetch model
module tb_stg_if;

  localparam int AW = 24;
  localparam int DW = 24;
  localparam int DEPTH = 4;
  localparam logic [23:0] OFS = 24'h100000;

  logic          iw_clk = 1'b0;
  logic          iw_rst;
  logic          iw_flush;
  logic [AW-1:0] iw_flush_pc;
  logic          iw_stall;
  logic          ow_imem_req;
  logic [AW-1:0] ow_imem_addr;
  logic          iw_imem_gnt;
  logic          iw_imem_rvalid;
  logic [DW-1:0] iw_imem_rdata;
  logic [AW-1:0] ow_pc;
  logic [DW-1:0] ow_instr;
  logic          ow_valid;

  always #5 iw_clk = ~iw_clk;

  stg_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .RESET_PC(24'h0)) dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_flush(iw_flush), .iw_flush_pc(iw_flush_pc),
    .iw_stall(iw_stall), .ow_imem_req(ow_imem_req), .ow_imem_addr(ow_imem_addr),
    .iw_imem_gnt(iw_imem_gnt), .iw_imem_rvalid(iw_imem_rvalid), .iw_imem_rdata(iw_imem_rdata),
    .ow_pc(ow_pc), .ow_instr(ow_instr), .ow_valid(ow_valid)
  );

  typedef struct {
    logic [23:0] addr;
    int          epoch;
  } req_t;

  req_t        pend[$];
  logic [23:0] exp_q[$];
  logic [23:0] granted[$];
  int          epoch;
  logic [23:0] next_fetch;
  logic [23:0] e_pc, e_instr;
  logic        e_valid;

  int          gnt_mode;
  int          rv_mode;
  bit          do_flush, do_stall;
  logic [23:0] flush_pc;

  int checks;
  int errors;

  // Responses belong to the epoch they were requested in; a flush starts a new epoch.
  task automatic cycle();
    logic g, r, exp_req;
    req_t h;
    g = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    if (pend.size() > 0)
      r = (rv_mode == 0) ? 1'b1 : (rv_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    else
      r = (rv_mode == 1) && ($urandom_range(0, 3) == 0);
    iw_imem_gnt    = g;
    iw_imem_rvalid = r;
    iw_imem_rdata  = (r && pend.size() > 0) ? pend[0].addr + OFS : 24'($urandom);
    iw_flush       = do_flush;
    iw_flush_pc    = flush_pc;
    iw_stall       = do_stall;
    #1;
    exp_req = !do_flush && ((pend.size() + exp_q.size()) < DEPTH);
    checks++;
    if (ow_imem_req !== exp_req)
      $display("FAIL req got %b exp %b", ow_imem_req, exp_req);
    if (ow_imem_req !== exp_req) errors++;
    if (ow_imem_req === 1'b1) begin
      checks++;
      if (ow_imem_addr !== next_fetch) begin
        errors++;
        $display("FAIL imem_addr got %h exp %h", ow_imem_addr, next_fetch);
      end
    end
    if (do_flush) begin
      e_pc = '0; e_instr = '0; e_valid = 1'b0;
    end else if (!do_stall) begin
      if (exp_q.size() > 0) begin
        e_pc = exp_q.pop_front(); e_instr = e_pc + OFS; e_valid = 1'b1;
      end else begin
        e_pc = '0; e_instr = '0; e_valid = 1'b0;
      end
    end
    if (r && pend.size() > 0) begin
      h = pend.pop_front();
      if (!do_flush && h.epoch == epoch) exp_q.push_back(h.addr);
    end
    if (ow_imem_req === 1'b1 && g) begin
      granted.push_back(ow_imem_addr);
      pend.push_back('{ow_imem_addr, epoch});
      next_fetch = next_fetch + 24'd1;
    end
    if (do_flush) begin
      exp_q.delete();
      epoch++;
      next_fetch = flush_pc;
    end
    @(posedge iw_clk);
    @(negedge iw_clk);
    checks += 3;
    if (ow_valid !== e_valid) begin
      errors++; $display("FAIL ow_valid got %b exp %b", ow_valid, e_valid);
    end
    if (ow_pc !== e_pc) begin
      errors++; $display("FAIL ow_pc got %h exp %h", ow_pc, e_pc);
    end
    if (ow_instr !== e_instr) begin
      errors++; $display("FAIL ow_instr got %h exp %h", ow_instr, e_instr);
    end
  endtask

  task automatic model_reset();
    pend.delete(); exp_q.delete(); granted.delete();
    epoch++; next_fetch = '0;
    e_pc = '0; e_instr = '0; e_valid = 1'b0;
  endtask

  task automatic test_reset();
    iw_rst = 1'b1; iw_flush = 0; iw_flush_pc = '0; iw_stall = 0;
    iw_imem_gnt = 0; iw_imem_rvalid = 0; iw_imem_rdata = '0;
    model_reset();
    @(negedge iw_clk); @(negedge iw_clk);
    checks++;
    if (ow_valid !== 1'b0 || ow_pc !== '0 || ow_instr !== '0 || ow_imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs got %b/%h/%h/%b exp 0/0/0/0", ow_valid, ow_pc, ow_instr, ow_imem_req);
    end
    iw_rst = 1'b0;
    #1;
    checks++;
    if (ow_imem_req !== 1'b1 || ow_imem_addr !== 24'h0) begin
      errors++; $display("FAIL reset_first_fetch got %b/%h exp 1/000000", ow_imem_req, ow_imem_addr);
    end
  endtask

  task automatic test_stream();
    bit seen;
    gnt_mode = 0; rv_mode = 0; do_flush = 0; do_stall = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (ow_valid === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || ow_pc !== 24'h0 || ow_instr !== 24'h100000) begin
      errors++; $display("FAIL first_valid got %b/%h/%h exp 1/000000/100000", seen, ow_pc, ow_instr);
    end
    for (int i = 0; i < 15; i++) cycle();
  endtask

  task automatic test_stall();
    do_stall = 1;
    for (int i = 0; i < 6; i++) cycle();
    iw_flush = 0;
    #1;
    checks++;
    if (ow_imem_req !== 1'b0) begin
      errors++; $display("FAIL stall_credit_full got %b exp 0", ow_imem_req);
    end
    do_stall = 0;
    for (int i = 0; i < 15; i++) cycle();
  endtask

  task automatic test_flush();
    rv_mode = 2; gnt_mode = 0;
    for (int i = 0; i < 10 && pend.size() < 2; i++) cycle();
    checks++;
    if (pend.size() != 2) begin
      errors++; $display("FAIL flush_setup got %0d exp 2", pend.size());
    end
    gnt_mode = 1; do_flush = 1; flush_pc = 24'h000040;
    cycle();
    checks++;
    if (ow_valid !== 1'b0) begin
      errors++; $display("FAIL flush_bubble got %b exp 0", ow_valid);
    end
    do_flush = 0; rv_mode = 0;
    cycle(); cycle();
    gnt_mode = 0;
    for (int i = 0; i < 20 && ow_valid !== 1'b1; i++) cycle();
    checks++;
    if (ow_valid !== 1'b1 || ow_pc !== 24'h000040) begin
      errors++; $display("FAIL flush_resume got %b/%h exp 1/000040", ow_valid, ow_pc);
    end
    for (int i = 0; i < 8; i++) cycle();
  endtask

  task automatic test_flush_stall();
    rv_mode = 0; gnt_mode = 0;
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (pend.size() == 0) begin
      errors++; $display("FAIL flush_stall_setup got 0 exp >0");
    end
    granted.delete();
    do_flush = 1; do_stall = 1; flush_pc = 24'h000200;
    cycle();
    checks++;
    if (ow_valid !== 1'b0 || ow_pc !== '0 || ow_instr !== '0) begin
      errors++; $display("FAIL flush_stall_outs got %b/%h/%h exp 0/0/0", ow_valid, ow_pc, ow_instr);
    end
    do_flush = 0; do_stall = 0;
    for (int i = 0; i < 6; i++) cycle();
    checks++;
    if (granted.size() == 0 || granted[0] !== 24'h000200) begin
      errors++; $display("FAIL flush_stall_resume got %h exp 000200", granted.size() ? granted[0] : 24'hx);
    end
  endtask

  task automatic test_gnt_low();
    logic [23:0] a0;
    gnt_mode = 1; rv_mode = 0;
    #0;
    a0 = next_fetch;
    for (int i = 0; i < 5; i++) cycle();
    iw_flush = 0;
    #1;
    checks += 2;
    if (ow_imem_req !== 1'b1 || ow_imem_addr !== a0) begin
      errors++; $display("FAIL gnt_low_hold got %b/%h exp 1/%h", ow_imem_req, ow_imem_addr, a0);
    end
    if (ow_valid !== 1'b0 || ow_instr !== '0) begin
      errors++; $display("FAIL gnt_low_bubble got %b/%h exp 0/000000", ow_valid, ow_instr);
    end
    gnt_mode = 0;
    for (int i = 0; i < 10; i++) cycle();
  endtask

  task automatic test_wrap();
    do_flush = 1; flush_pc = 24'hFFFFFF;
    cycle();
    do_flush = 0;
    granted.delete();
    for (int i = 0; i < 12; i++) cycle();
    checks++;
    if (granted.size() < 2 || granted[0] !== 24'hFFFFFF || granted[1] !== 24'h000000) begin
      errors++; $display("FAIL wrap_fetch got %0d entries exp FFFFFF then 000000", granted.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      gnt_mode = 2; rv_mode = 1;
      do_stall = ($urandom_range(0, 3) == 0);
      do_flush = ($urandom_range(0, 19) == 0);
      flush_pc = 24'($urandom);
      cycle();
    end
    do_flush = 0; do_stall = 0;
  endtask

  task automatic test_reset_mid();
    gnt_mode = 0; rv_mode = 2;
    for (int i = 0; i < 3; i++) cycle();
    #2;
    iw_rst = 1'b1;
    iw_imem_rvalid = 0; iw_imem_gnt = 0;
    #1;
    checks++;
    if (ow_valid !== 1'b0 || ow_pc !== '0 || ow_instr !== '0 || ow_imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got %b/%h/%h/%b exp 0/0/0/0", ow_valid, ow_pc, ow_instr, ow_imem_req);
    end
    model_reset();
    @(negedge iw_clk);
    iw_rst = 1'b0;
    rv_mode = 0;
    for (int i = 0; i < 12; i++) cycle();
    checks++;
    if (granted.size() == 0 || granted[0] !== 24'h000000) begin
      errors++; $display("FAIL reset_restart got %0d entries exp first 000000", granted.size());
    end
  endtask

  initial begin
    checks = 0; errors = 0; epoch = 0;
    gnt_mode = 0; rv_mode = 0; do_flush = 0; do_stall = 0; flush_pc = '0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_flush_stall();
    test_gnt_low();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
